i2c_target_regs: RTL and testbench
==================================

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 SHALL provide parameter I2CAddress, default 7'h55, the 7-bit target address this block answers to.
REQ-002 SHALL provide parameter FilterDepth, default 3, the number of consecutive identical clk samples needed before a filtered SCL/SDA value changes.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL provide port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL provide port scl, inout tri1, 1 bit: I2C clock; the block only samples it and never drives it (no clock stretching).
REQ-006 SHALL provide port sda, inout tri1, 1 bit: I2C data; the block drives only 1'b0 or 1'bz, never 1'b1.
REQ-007 SHALL provide port reg_addr, output, 8 bits: equals the current register pointer at all times.
REQ-008 SHALL provide port reg_wdata, output, 8 bits: the received write byte, valid while reg_we is high.
REQ-009 SHALL provide port reg_we, output, 1 bit: single-clk write strobe.
REQ-010 SHALL provide port reg_rdata, input, 8 bits: register contents at reg_addr, sampled combinationally on the load cycle.
REQ-011 SHALL provide port busy, output, 1 bit: high from address match until the next STOP or START.

Function
REQ-012 SHALL pass scl and sda through 2-FF synchronizers followed by the FilterDepth filter; synchronizer and filter state reset to 1.
REQ-013 SHALL detect START when filtered SDA falls while filtered SCL is high, and STOP when filtered SDA rises while filtered SCL is high; both are one-cycle internal events.
REQ-014 SHALL use states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WRITE_ACK, READ, READ_ACK and IGNORE.
REQ-015 SHALL go to ADDR on START from any state, including a repeated START mid-transfer, and clear the bit counter.
REQ-016 SHALL go to IDLE on STOP from any state, release SDA and deassert busy.
REQ-017 SHALL shift received bits in MSB first on each filtered SCL rising edge.
REQ-018 SHALL change the SDA drive only on the cycle after a filtered SCL falling edge.
REQ-019 SHALL, after 8 address bits, on a match go to ADDR_ACK, drive SDA low for the 9th bit and assert busy; otherwise go to IGNORE without ACK.
REQ-020 SHALL, when R/W=0, go from ADDR_ACK to PTR; the next byte loads the pointer, is ACKed in PTR_ACK, and is followed by WRITE.
REQ-021 SHALL, in WRITE, after the 8th bit rising edge, pulse reg_we for one clk with reg_wdata = byte and reg_addr = old pointer.
REQ-022 SHALL, in WRITE, increment the pointer modulo 256 on the cycle after the reg_we pulse, ACK in WRITE_ACK, then return to WRITE.
REQ-023 SHALL, when R/W=1, on the SCL falling edge ending ADDR_ACK, load the shifter from reg_rdata, go to READ and drive bit 7 (0 -> SDA low, 1 -> release).
REQ-024 SHALL, in READ_ACK, release SDA and sample the controller's bit on the 9th rising edge.
REQ-025 SHALL, on a READ_ACK ACK (SDA low), increment the pointer modulo 256, load the next byte at the following falling edge and continue READ.
REQ-026 SHALL, on a READ_ACK NACK, keep the pointer incremented, release SDA and go to IGNORE.
REQ-027 SHALL retain the pointer across transactions, so a pointer write, repeated START and read returns the byte at that pointer.
REQ-028 SHALL wrap the pointer from 8'hFF to 8'h00 on both write and read auto-increment.
REQ-029 SHALL release SDA and ignore all bits in IGNORE until START or STOP.
REQ-030 SHALL never assert reg_we in IGNORE, PTR or any read state.

Reset
REQ-031 SHALL, while reset_n is low, immediately and asynchronously hold state IDLE, pointer 8'h00, reg_we 0, reg_wdata 8'h00, busy 0 and SDA released.
REQ-032 SHALL, if reset is asserted mid-transaction, generate no reg_we and not drive SDA after release, and wait for a fresh START.

Verification
REQ-033 SHALL be verified by: START, 0xAA (0x55+W), 0x10, 0x3C, 0x7E, STOP -> three ACKs, reg_we pulses at addr 0x10 data 0x3C and addr 0x11 data 0x7E, final pointer 0x12.
REQ-034 SHALL be verified by: START, 0xAA, 0x20, repeated START, 0xAB, read two bytes (ACK then NACK), with regs 0x20=0xA5 and 0x21=0x5A -> SDA bits A5 then 5A, final pointer 0x22.
REQ-035 SHALL be verified by: START, 0x54 (0x2A+W), 0x00, STOP -> no ACK, SDA never low, busy 0, no reg_we.
REQ-036 SHALL be verified by: pointer 0xFF, write 0x11, 0x22 -> writes at 0xFF then 0x00, final pointer 0x01.
REQ-037 SHALL be verified by: 1-clk SCL glitches during a byte with FilterDepth=3 -> received byte unchanged.
REQ-038 SHALL be verified by: reset_n low during the ACK of PTR -> SDA released in the same cycle, pointer 0x00, no reg_we, and the next valid transaction behaves as REQ-033.

Source files
------------

// File: rtl/i2c_target_regs_if.sv
// Register-side bus of the I2C target: pointer, write strobe/data, read data and busy.
`timescale 1ns/1ps
interface i2c_target_regs_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic [7:0] reg_rdata;
  logic       busy;

  // I2C target side drives the pointer/strobe; the register file returns read data.
  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output busy,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  busy,
    output reg_rdata
  );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target with an 8-bit register pointer: first data byte after the address sets the
// pointer, further bytes are written with auto-increment; reads stream from the pointer.
`timescale 1ns/1ps
module i2c_target_regs #(
  parameter logic [6:0]  I2CAddress  = 7'h55,
  parameter int unsigned FilterDepth = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  inout  tri1               scl,
  inout  tri1               sda,
  i2c_target_regs_if.master bus
);

  localparam int unsigned CntW = (FilterDepth > 1) ? $clog2(FilterDepth) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FilterDepth - 1);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
    StWrite, StWriteAck, StRead, StReadAck, StIgnore
  } state_e;

  // Input conditioning
  logic            scl_meta_q, scl_sync_q, sda_meta_q, sda_sync_q;
  logic [CntW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  logic            scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic            scl_prev_q, sda_prev_q;

  // Protocol state
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       busy_q, busy_d;
  logic       oe_q, oe_d;
  logic       rw_q, rw_d;
  logic       ph_q, ph_d;      // ACK bit already being driven
  logic       rack_q, rack_d;  // controller ACKed the last read byte

  logic scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0] byte_in;

  // Open-drain data output; SCL is only ever sampled.
  assign sda = oe_q ? 1'b0 : 1'bz;

  assign bus.reg_addr  = ptr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.busy      = busy_q;

  // Glitch filters: output follows the synced input after FilterDepth agreeing samples.
  always_comb begin
    scl_cnt_d = scl_cnt_q;
    scl_f_d   = scl_f_q;
    sda_cnt_d = sda_cnt_q;
    sda_f_d   = sda_f_q;
    if (scl_sync_q == scl_f_q) begin
      scl_cnt_d = '0;
    end else if (scl_cnt_q == CntMax) begin
      scl_f_d   = scl_sync_q;
      scl_cnt_d = '0;
    end else begin
      scl_cnt_d = scl_cnt_q + 1'b1;
    end
    if (sda_sync_q == sda_f_q) begin
      sda_cnt_d = '0;
    end else if (sda_cnt_q == CntMax) begin
      sda_f_d   = sda_sync_q;
      sda_cnt_d = '0;
    end else begin
      sda_cnt_d = sda_cnt_q + 1'b1;
    end
  end

  // Synchronizer, filter and edge-history registers; idle bus level is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl;
      scl_sync_q <= scl_meta_q;
      sda_meta_q <= sda;
      sda_sync_q <= sda_meta_q;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_prev_q <= scl_f_q;
      sda_prev_q <= sda_f_q;
    end
  end

  assign scl_rise = scl_f_q & ~scl_prev_q;
  assign scl_fall = ~scl_f_q & scl_prev_q;
  assign start_ev = sda_prev_q & ~sda_f_q & scl_f_q & scl_prev_q;
  assign stop_ev  = ~sda_prev_q & sda_f_q & scl_f_q & scl_prev_q;
  assign byte_in  = {shift_q[6:0], sda_f_q};

  // Next-state logic for the byte/bit protocol engine.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    busy_d  = busy_q;
    oe_d    = oe_q;
    rw_d    = rw_q;
    ph_d    = ph_q;
    rack_d  = rack_q;

    // Pointer advances the cycle after the write strobe.
    if (we_q) ptr_d = ptr_q + 8'd1;

    if (start_ev) begin
      state_d = StAddr;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      ph_d    = 1'b0;
    end else if (stop_ev) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      ph_d    = 1'b0;
    end else begin
      unique case (state_q)
        StAddr, StPtr, StWrite: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = '0;
              if (state_q == StAddr) begin
                if (byte_in[7:1] == I2CAddress) begin
                  state_d = StAddrAck;
                  rw_d    = byte_in[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = StIgnore;
                end
              end else if (state_q == StPtr) begin
                ptr_d   = byte_in;
                state_d = StPtrAck;
              end else begin
                we_d    = 1'b1;
                wdata_d = byte_in;
                state_d = StWriteAck;
              end
            end
          end
        end
        StAddrAck, StPtrAck, StWriteAck: begin
          // First fall starts the ACK bit, second fall ends it.
          if (scl_fall) begin
            if (!ph_q) begin
              oe_d = 1'b1;
              ph_d = 1'b1;
            end else begin
              ph_d  = 1'b0;
              oe_d  = 1'b0;
              cnt_d = '0;
              if (state_q == StAddrAck && rw_q) begin
                shift_d = bus.reg_rdata;
                oe_d    = ~bus.reg_rdata[7];
                state_d = StRead;
              end else if (state_q == StAddrAck) begin
                state_d = StPtr;
              end else begin
                state_d = StWrite;
              end
            end
          end
        end
        StRead: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              state_d = StReadAck;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
        end
        StReadAck: begin
          if (scl_rise) begin
            rack_d = ~sda_f_q;
            ptr_d  = ptr_q + 8'd1;
          end else if (scl_fall) begin
            if (rack_q) begin
              shift_d = bus.reg_rdata;
              oe_d    = ~bus.reg_rdata[7];
              cnt_d   = '0;
              state_d = StRead;
            end else begin
              oe_d    = 1'b0;
              state_d = StIgnore;
            end
          end
        end
        StIdle, StIgnore: begin
          oe_d = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Protocol state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      ptr_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      oe_q    <= 1'b0;
      rw_q    <= 1'b0;
      ph_q    <= 1'b0;
      rack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ptr_q   <= ptr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      oe_q    <= oe_d;
      rw_q    <= rw_d;
      ph_q    <= ph_d;
      rack_q  <= rack_d;
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: bit-banged I2C controller against the target and a 256-byte register model.
`timescale 1ns/1ps
module tb_i2c_target_regs;

  localparam int Q = 10;  // clk cycles per quarter SCL period

  logic clk;
  logic reset_n;
  logic scl_low;
  logic sda_low;
  tri1  scl_w;
  tri1  sda_w;

  i2c_target_regs_if bus ();

  i2c_target_regs #(
    .I2CAddress  (7'h55),
    .FilterDepth (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .scl     (scl_w),
    .sda     (sda_w),
    .bus     (bus)
  );

  assign scl_w = scl_low ? 1'b0 : 1'bz;
  assign sda_w = sda_low ? 1'b0 : 1'bz;

  logic [7:0] mem [256];
  assign bus.reg_rdata = mem[bus.reg_addr];

  int n_checks = 0;
  int n_bad    = 0;

  logic [7:0] we_addr [$];
  logic [7:0] we_data [$];
  int         dut_low = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record write strobes and any cycle where the target pulls SDA low.
  always @(negedge clk) begin
    if (bus.reg_we === 1'b1) begin
      we_addr.push_back(bus.reg_addr);
      we_data.push_back(bus.reg_wdata);
    end
    if (!sda_low && sda_w === 1'b0) dut_low++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Works from idle (both high) and as a repeated START from SCL low.
  task automatic i2c_start();
    sda_low = 1'b0;
    tick(Q);
    scl_low = 1'b0;
    tick(2 * Q);
    sda_low = 1'b1;
    tick(2 * Q);
    scl_low = 1'b1;
    tick(Q);
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1;
    tick(Q);
    scl_low = 1'b0;
    tick(2 * Q);
    sda_low = 1'b0;
    tick(2 * Q);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    sda_low = ~b;
    tick(Q);
    scl_low = 1'b0;
    tick(Q);
    if (glitch) begin
      scl_low = 1'b1;
      tick(1);
      scl_low = 1'b0;
      tick(Q - 1);
    end else begin
      tick(Q);
    end
    scl_low = 1'b1;
    if (glitch) begin
      tick(Q / 2);
      scl_low = 1'b0;
      tick(1);
      scl_low = 1'b1;
      tick(Q - Q / 2 - 1);
    end else begin
      tick(Q);
    end
  endtask

  task automatic read_bit(output logic b);
    sda_low = 1'b0;
    tick(Q);
    scl_low = 1'b0;
    tick(Q);
    b = sda_w;
    tick(Q);
    scl_low = 1'b1;
    tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic glitch, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i], glitch);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    send_bit(~ack, 1'b0);
  endtask

  // START, 0xAA, 0x10, 0x3C, 0x7E, STOP.
  task automatic basic_write(input string tag);
    logic ack;
    int   base;
    base = we_addr.size();
    i2c_start();
    send_byte(8'hAA, 1'b0, ack);
    check({tag, "_addr_ack"}, 32'(ack), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    send_byte(8'h10, 1'b0, ack);
    check({tag, "_ptr_ack"}, 32'(ack), 32'd1);
    send_byte(8'h3C, 1'b0, ack);
    check({tag, "_d0_ack"}, 32'(ack), 32'd1);
    send_byte(8'h7E, 1'b0, ack);
    check({tag, "_d1_ack"}, 32'(ack), 32'd1);
    i2c_stop();
    tick(Q);
    check({tag, "_we_count"}, 32'(we_addr.size() - base), 32'd2);
    if (we_addr.size() >= base + 2) begin
      check({tag, "_we0_addr"}, 32'(we_addr[base]), 32'h10);
      check({tag, "_we0_data"}, 32'(we_data[base]), 32'h3C);
      check({tag, "_we1_addr"}, 32'(we_addr[base + 1]), 32'h11);
      check({tag, "_we1_data"}, 32'(we_data[base + 1]), 32'h7E);
    end
    check({tag, "_ptr_final"}, 32'(bus.reg_addr), 32'h12);
    check({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         base;
    int         low0;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'hA5;
    mem[8'h21] = 8'h5A;
    scl_low = 1'b0;
    sda_low = 1'b0;
    reset_n = 1'b0;
    tick(3);
    #1;
    check("rst_addr", 32'(bus.reg_addr), 32'h00);
    check("rst_we", 32'(bus.reg_we), 32'd0);
    check("rst_wdata", 32'(bus.reg_wdata), 32'h00);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sda", 32'(sda_w), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    tick(2 * Q);

    basic_write("wr");

    // Wrong address: no ACK, no SDA drive, no writes.
    base = we_addr.size();
    low0 = dut_low;
    i2c_start();
    send_byte(8'h54, 1'b0, ack);
    check("nack_addr", 32'(ack), 32'd0);
    check("nack_busy", 32'(bus.busy), 32'd0);
    send_byte(8'h00, 1'b0, ack);
    check("nack_data", 32'(ack), 32'd0);
    i2c_stop();
    tick(Q);
    check("nack_sda_low", 32'(dut_low - low0), 32'd0);
    check("nack_we", 32'(we_addr.size() - base), 32'd0);
    check("nack_ptr", 32'(bus.reg_addr), 32'h12);

    // Pointer wrap on write.
    base = we_addr.size();
    i2c_start();
    send_byte(8'hAA, 1'b0, ack);
    send_byte(8'hFF, 1'b0, ack);
    send_byte(8'h11, 1'b0, ack);
    send_byte(8'h22, 1'b0, ack);
    check("wrap_ack", 32'(ack), 32'd1);
    i2c_stop();
    tick(Q);
    check("wrap_we_count", 32'(we_addr.size() - base), 32'd2);
    if (we_addr.size() >= base + 2) begin
      check("wrap_we0_addr", 32'(we_addr[base]), 32'hFF);
      check("wrap_we0_data", 32'(we_data[base]), 32'h11);
      check("wrap_we1_addr", 32'(we_addr[base + 1]), 32'h00);
      check("wrap_we1_data", 32'(we_data[base + 1]), 32'h22);
    end
    check("wrap_ptr", 32'(bus.reg_addr), 32'h01);

    // Pointer write, repeated START, two-byte read.
    base = we_addr.size();
    i2c_start();
    send_byte(8'hAA, 1'b0, ack);
    send_byte(8'h20, 1'b0, ack);
    i2c_start();
    send_byte(8'hAB, 1'b0, ack);
    check("rd_addr_ack", 32'(ack), 32'd1);
    recv_byte(1'b1, d);
    check("rd_byte0", 32'(d), 32'hA5);
    recv_byte(1'b0, d);
    check("rd_byte1", 32'(d), 32'h5A);
    i2c_stop();
    tick(Q);
    check("rd_ptr", 32'(bus.reg_addr), 32'h22);
    check("rd_no_we", 32'(we_addr.size() - base), 32'd0);

    // SCL glitches inside the pointer and data bytes.
    base = we_addr.size();
    i2c_start();
    send_byte(8'hAA, 1'b0, ack);
    send_byte(8'h40, 1'b1, ack);
    check("gl_ptr_ack", 32'(ack), 32'd1);
    send_byte(8'h96, 1'b1, ack);
    check("gl_data_ack", 32'(ack), 32'd1);
    i2c_stop();
    tick(Q);
    check("gl_we_count", 32'(we_addr.size() - base), 32'd1);
    if (we_addr.size() >= base + 1) begin
      check("gl_we_addr", 32'(we_addr[base]), 32'h40);
      check("gl_we_data", 32'(we_data[base]), 32'h96);
    end
    check("gl_ptr", 32'(bus.reg_addr), 32'h41);

    // Reset during the pointer-byte ACK.
    base = we_addr.size();
    i2c_start();
    send_byte(8'hAA, 1'b0, ack);
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h10 >> i), 1'b0);
    sda_low = 1'b0;
    tick(Q);
    check("rst_mid_ack_drv", 32'(sda_w), 32'd0);
    check("rst_mid_ptr_pre", 32'(bus.reg_addr), 32'h10);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_mid_sda", 32'(sda_w), 32'd1);
    check("rst_mid_ptr", 32'(bus.reg_addr), 32'h00);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    tick(5);
    @(negedge clk);
    reset_n = 1'b1;
    low0 = dut_low;
    tick(Q);
    scl_low = 1'b0;
    tick(2 * Q);
    scl_low = 1'b1;
    tick(Q);
    i2c_stop();
    tick(Q);
    check("rst_mid_no_drive", 32'(dut_low - low0), 32'd0);
    check("rst_mid_no_we", 32'(we_addr.size() - base), 32'd0);

    basic_write("wr2");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
